// File: rtl/run_signature_ctrl_pkg.sv
// run_sig_pkg: shared types and helpers for run_signature_ctrl.
//   state_t   - controller FSM states
//   WC_WIDTH  - width of the batch word counter
//   xor_fold  - XOR of the din_w/out_w slices of a word (result in low out_w bits)
//   rotl1     - rotate the low w bits of a word left by one
// Helpers work on a fixed MAX_W-wide container so callers with any
// DIN_WIDTH <= MAX_W can share them; unused upper bits are zero.
package run_sig_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        GAP,
        SIG
    } state_t;

    localparam int unsigned WC_WIDTH = 32;
    localparam int unsigned MAX_W    = 256;
    localparam int unsigned IDX_W    = $clog2(MAX_W);

    typedef logic [MAX_W-1:0] wide_t;
    typedef logic [IDX_W-1:0] idx_t;

    function automatic wide_t xor_fold(input wide_t word, input int unsigned din_w,
                                       input int unsigned out_w);
        wide_t res;
        res = '0;
        // Bit i of the word lands on bit (i mod out_w) of the fold.
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < din_w) begin
                res[idx_t'(i % out_w)] = res[idx_t'(i % out_w)] ^ word[idx_t'(i)];
            end
        end
        return res;
    endfunction

    function automatic wide_t rotl1(input wide_t word, input int unsigned w);
        wide_t res;
        res = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                res[idx_t'(i)] = word[idx_t'((i + w - 1) % w)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/run_signature_ctrl_trigger_sync.sv
// trigger_sync: synchronises an asynchronous trigger and emits a one-cycle
// registered pulse on its rising edge.
//   ap_clk   - clock
//   ap_rst_n - synchronous active-low reset
//   async_in - asynchronous level input
//   edge_out - one-cycle pulse, SYNC_STAGES+1 edges after async_in is first sampled high
module trigger_sync #(
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic async_in,
    output logic edge_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   edge_q;

    // The chain resets to the "high" level: a trigger still asserted when
    // reset releases looks like a steady level, not a new rising edge, so it
    // must fall and rise again before it can launch.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
            edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign edge_out = edge_q;

endmodule

// File: rtl/run_signature_ctrl.sv
// run_signature_ctrl: launches an HLS kernel num_runs times per trigger,
// folds every written channel word onto a narrow live output, and
// accumulates a batch signature and word count.
//   ap_clk, ap_rst_n        - clock, synchronous active-low reset
//   trigger                 - asynchronous launch request
//   num_runs                - runs per batch (0 treated as 1), sampled on launch
//   ap_start / ap_done      - kernel handshake
//   ch_din/ch_write         - NUM_CH output channels; ch_full_n high while busy
//   data_out/data_valid     - live folded stream, 2-cycle latency
//   sig_out/word_count      - batch results, valid with sig_valid, held until next launch
//   busy                    - high outside IDLE
module run_signature_ctrl
    import run_sig_pkg::*;
#(
    parameter int unsigned NUM_CH        = 1,
    parameter int unsigned DIN_WIDTH     = 32,
    parameter int unsigned OUT_WIDTH     = 4,
    parameter int unsigned RUN_CNT_WIDTH = 8,
    parameter int unsigned SYNC_STAGES   = 3
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        trigger,
    input  logic [RUN_CNT_WIDTH-1:0]    num_runs,
    output logic                        ap_start,
    input  logic                        ap_done,
    input  logic [NUM_CH*DIN_WIDTH-1:0] ch_din,
    input  logic [NUM_CH-1:0]           ch_write,
    output logic [NUM_CH-1:0]           ch_full_n,
    output logic [OUT_WIDTH-1:0]        data_out,
    output logic                        data_valid,
    output logic [DIN_WIDTH-1:0]        sig_out,
    output logic [WC_WIDTH-1:0]         word_count,
    output logic                        sig_valid,
    output logic                        busy
);

    state_t                   state_q, state_d;
    logic [RUN_CNT_WIDTH-1:0] runs_q, runs_d;
    logic [RUN_CNT_WIDTH-1:0] run_cnt_q, run_cnt_d, run_cnt_inc;
    logic [DIN_WIDTH-1:0]     sig_q, sig_d, mixed;
    logic [WC_WIDTH-1:0]      wc_q, wc_d, wr_cnt;
    wide_t                    fold_wide, rot_wide;
    logic                     trig_edge;

    logic                     ap_start_q, busy_q, sig_valid_q;
    logic [NUM_CH-1:0]        full_q;
    logic [OUT_WIDTH-1:0]     fold1_q, data_out_q;
    logic                     v1_q, data_valid_q;

    trigger_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_trigger_sync (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .async_in(trigger),
        .edge_out(trig_edge)
    );

    // XOR-folding is linear, so folding the XOR of the masked channel words
    // equals XORing the per-channel folds; one fold serves all channels.
    always_comb begin
        mixed  = '0;
        wr_cnt = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ch_write[k]) begin
                mixed = mixed ^ ch_din[k*DIN_WIDTH +: DIN_WIDTH];
            end
            wr_cnt = wr_cnt + WC_WIDTH'(ch_write[k]);
        end
        fold_wide = xor_fold(wide_t'(mixed), DIN_WIDTH, OUT_WIDTH);
        rot_wide  = rotl1(wide_t'(sig_q), DIN_WIDTH);
    end

    always_comb begin
        state_d     = state_q;
        runs_d      = runs_q;
        run_cnt_d   = run_cnt_q;
        sig_d       = sig_q;
        wc_d        = wc_q;
        run_cnt_inc = run_cnt_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (trig_edge) begin
                    runs_d    = (num_runs == '0) ? RUN_CNT_WIDTH'(1) : num_runs;
                    run_cnt_d = '0;
                    sig_d     = '0;
                    wc_d      = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (ap_done) begin
                    run_cnt_d = run_cnt_inc;
                    state_d   = (run_cnt_inc == runs_q) ? SIG : GAP;
                end
            end
            GAP:     state_d = START;
            SIG:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if ((state_q == START || state_q == GAP) && (|ch_write)) begin
            sig_d = rot_wide[DIN_WIDTH-1:0] ^ mixed;
            wc_d  = wc_q + wr_cnt;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q      <= IDLE;
            runs_q       <= '0;
            run_cnt_q    <= '0;
            sig_q        <= '0;
            wc_q         <= '0;
            ap_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            full_q       <= '0;
            sig_valid_q  <= 1'b0;
            fold1_q      <= '0;
            v1_q         <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            runs_q       <= runs_d;
            run_cnt_q    <= run_cnt_d;
            sig_q        <= sig_d;
            wc_q         <= wc_d;
            ap_start_q   <= (state_d == START);
            busy_q       <= (state_d != IDLE);
            full_q       <= {NUM_CH{state_d != IDLE}};
            sig_valid_q  <= (state_d == SIG);
            fold1_q      <= fold_wide[OUT_WIDTH-1:0];
            v1_q         <= |ch_write;
            data_valid_q <= v1_q;
            data_out_q   <= v1_q ? fold1_q : '0;
        end
    end

    assign ap_start   = ap_start_q;
    assign busy       = busy_q;
    assign ch_full_n  = full_q;
    assign sig_valid  = sig_valid_q;
    assign sig_out    = sig_q;
    assign word_count = wc_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

endmodule

// File: doc/run_signature_ctrl.md
# run_signature_ctrl

Parametrised output/launch controller placed between a debug-probe trigger and an HLS kernel's ap_* control and FIFO-style output ports. It launches the kernel a programmable number of back-to-back times per trigger, folds every output word of every output channel into a narrow live pin stream, and accumulates a whole-batch signature plus word count for checking on hardware. It generalises the single-channel, single-run XOR output stage to N channels, arbitrary widths and multi-run batches.

## Interface
- NUM_CH, 1, number of kernel output channels
- DIN_WIDTH, 32, width of each channel word; must be a multiple of OUT_WIDTH
- OUT_WIDTH, 4, width of live folded output
- RUN_CNT_WIDTH, 8, width of run counter / num_runs
- SYNC_STAGES, 3, synchroniser depth for trigger (min 2)

- ap_clk  in  1  sole clock
- ap_rst_n  in  1  synchronous, active-low reset
- trigger  in  1  asynchronous launch request (probe output)
- num_runs  in  RUN_CNT_WIDTH  kernel invocations per trigger, sampled on launch; 0 treated as 1
- ap_start  out  1  kernel start
- ap_done  in  1  kernel done pulse
- ch_din  in  NUM_CH*DIN_WIDTH  channel words, channel k at [k*DIN_WIDTH +: DIN_WIDTH]
- ch_write  in  NUM_CH  per-channel write strobe
- ch_full_n  out  NUM_CH  all bits 1 while busy, 0 in IDLE
- data_out  out  OUT_WIDTH  live folded output
- data_valid  out  1  data_out qualifier
- sig_out  out  DIN_WIDTH  batch signature, held until next launch
- word_count  out  32  total words written in batch, held until next launch
- sig_valid  out  1  one-cycle pulse at batch end
- busy  out  1  high in any state except IDLE

## Operation
- Trigger: SYNC_STAGES flop synchroniser, then rising-edge detect against one further flop. Edges outside IDLE are ignored, not queued.
- FSM states: IDLE, START, GAP, SIG.
  - IDLE: on detected edge, latch num_runs (0 becomes 1), clear run_cnt, sig_acc, word_count; go to START.
  - START: ap_start=1. On ap_done, run_cnt+1. If that equals the latched runs, go to SIG. Otherwise go to GAP.
  - GAP: ap_start=0 for exactly one cycle, then go to START.
  - SIG: sig_valid=1 for one cycle, then go to IDLE.
- Live path, stage 1:
  - Per channel, mask the word with ch_write[k].
  - XOR-fold the word into OUT_WIDTH by XOR of its DIN_WIDTH/OUT_WIDTH slices.
  - XOR all channel folds together.
  - v1 = |ch_write.
- Live path, stage 2: data_valid <= v1; data_out <= v1 ? fold : 0.
- Live path operates in every state; writes in IDLE still appear on data_out.
- Signature: on any cycle in START/GAP with |ch_write, sig_acc <= rotl(sig_acc,1) ^ (XOR of masked channel words).
- Word count: in the same cycles, word_count += popcount(ch_write), wrapping modulo 2^32.
- Writes in IDLE/SIG do not touch sig_acc or word_count.
- sig_out mirrors sig_acc. sig_out and word_count are valid when sig_valid=1 and remain stable through IDLE.

## Timing
- Reset (ap_rst_n=0 at a clock edge): state IDLE. All outputs are 0: ap_start, data_out, data_valid, sig_out, word_count, sig_valid, busy, ch_full_n.
- Reset mid-batch aborts immediately, with ap_start=0 on the next cycle. The synchroniser and edge-detect flops are cleared too, so a trigger held high through reset release does not launch.
- Trigger-to-ap_start: ap_start is high SYNC_STAGES+2 cycles after the first ap_clk edge sampling trigger high.
- ap_done to next ap_start rising: 2 cycles (GAP), when runs remain.
- ap_done on the last run to sig_valid: 1 cycle. A write coincident with that ap_done is included in sig_out/word_count.
- Live output latency: ch_write/ch_din to data_out/data_valid is 2 cycles, fully pipelined, one word per cycle per channel.
- ap_done in IDLE, GAP or SIG is ignored.

## Structure
- Package run_sig_pkg holds:
  - the state enum (IDLE, START, GAP, SIG)
  - function xor_fold(word, DIN_WIDTH, OUT_WIDTH)
  - function rotl1
  - the word-count width constant (32)
- One sub-module, trigger_sync: SYNC_STAGES synchroniser plus rising-edge detect, ports ap_clk, ap_rst_n, async_in, edge_out.

## Test plan
- Single channel, DIN_WIDTH=32, OUT_WIDTH=4, num_runs=1. Drive one write of 32'h12345678 during the run -> data_out=4'h8 with data_valid two cycles later; sig_out=32'h12345678, word_count=1 at sig_valid.
- NUM_CH=2, simultaneous writes 32'hFFFF0000 / 32'h0000FFFF, then ch1 only 32'h1 -> live folds 4'h0 then 4'h1; sig_out = rotl(32'hFFFFFFFF,1)^1 = 32'hFFFFFFFE; word_count=3.
- num_runs=3 with kernel model done after 10 cycles -> exactly three ap_start high periods, each separated by one low cycle; one sig_valid pulse; num_runs=0 gives one run.
- Trigger toggled while busy, and ap_done pulsed in IDLE -> no extra launch, no state change.
- Reset asserted mid-run with trigger held high -> all outputs 0 next cycle; no launch after release until trigger falls and rises again.
